// File: rtl/if_id_if.sv
// Handshake bundle between fetch/hazard logic (master) and the IF/ID stage (slave).
interface if_id_if;
  logic [15:0] pc_in;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        bubble_enable;
  logic        flush;
  logic        imem_read;
  logic        pc_load;
  logic [15:0] ir_out;
  logic [15:0] pc_out;
  logic [3:0]  opcode_out;
  logic [2:0]  sr1_out;
  logic [2:0]  sr2_out;
  logic        is_nop;

  modport master (
    output pc_in, imem_rdata, imem_resp, bubble_enable, flush,
    input  imem_read, pc_load, ir_out, pc_out, opcode_out, sr1_out, sr2_out, is_nop
  );

  modport slave (
    input  pc_in, imem_rdata, imem_resp, bubble_enable, flush,
    output imem_read, pc_load, ir_out, pc_out, opcode_out, sr1_out, sr2_out, is_nop
  );
endinterface

// File: rtl/if_id_stage.sv
// LC-3b IF/ID register: latches fetched instruction and PC+2, decodes register fields,
// and after a control op suspends fetch for SHADOW_CYCLES while the branch resolves.
module if_id_stage #(
  parameter int unsigned SHADOW_CYCLES = 3,
  parameter logic [15:0] NOP_INSTR     = 16'h0000
) (
  input  logic   clk,
  input  logic   rst_n,
  if_id_if.slave bus
);
  localparam logic [3:0] OP_BR  = 4'h0;
  localparam logic [3:0] OP_JSR = 4'h4;
  localparam logic [3:0] OP_JMP = 4'hC;

  typedef enum logic {FETCH, SHADOW} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic        nop_q, nop_d;
  logic        ctrl_op;

  assign bus.ir_out     = ir_q;
  assign bus.pc_out     = pc_q;
  assign bus.is_nop     = nop_q;
  assign bus.opcode_out = ir_q[15:12];
  assign bus.sr1_out    = ir_q[8:6];
  assign bus.sr2_out    = ir_q[2:0];

  // An injected NOP also decodes as BR, so it must not re-trigger the shadow.
  assign ctrl_op = ((ir_q[15:12] == OP_BR) && !nop_q) ||
                   (ir_q[15:12] == OP_JMP) || (ir_q[15:12] == OP_JSR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= 4'd0;
      ir_q    <= NOP_INSTR;
      pc_q    <= 16'h0000;
      nop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      nop_q   <= nop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ir_d    = NOP_INSTR;
    nop_d   = 1'b1;
    pc_d    = pc_q;
    case (state_q)
      FETCH: begin
        if (bus.flush) begin
          state_d = FETCH;
        end else if (bus.bubble_enable) begin
          if (ctrl_op) begin
            state_d = SHADOW;
            cnt_d   = 4'(SHADOW_CYCLES - 1);
          end else begin
            ir_d  = ir_q;
            nop_d = nop_q;
          end
        end else if (bus.imem_resp) begin
          ir_d  = bus.imem_rdata;
          pc_d  = bus.pc_in + 16'd2;
          nop_d = 1'b0;
        end
      end
      SHADOW: begin
        if (bus.flush) begin
          state_d = FETCH;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // PC control is combinational so the PC register sees it in the same cycle.
  always_comb begin
    bus.imem_read = 1'b0;
    bus.pc_load   = 1'b0;
    if (rst_n) begin
      if (state_q == FETCH) begin
        bus.imem_read = 1'b1;
        bus.pc_load   = bus.flush | (~bus.bubble_enable & bus.imem_resp);
      end else begin
        bus.pc_load   = bus.flush;
      end
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: directed scenarios plus random traffic on two instances
// (SHADOW_CYCLES=3 and 1) checked against a cycle-level reference model.
module tb_if_id_stage;
  logic clk;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  if_id_if bus0();
  if_id_if bus1();

  if_id_stage #(.SHADOW_CYCLES(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  if_id_stage #(.SHADOW_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus1.pc_in         = bus0.pc_in;
  assign bus1.imem_rdata    = bus0.imem_rdata;
  assign bus1.imem_resp     = bus0.imem_resp;
  assign bus1.bubble_enable = bus0.bubble_enable;
  assign bus1.flush         = bus0.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: shadow expressed as cycles still to spend in shadow (0 = fetching).
  logic [15:0] m_ir [2];
  logic [15:0] m_pc [2];
  logic        m_nop[2];
  int          m_rem[2];
  int          sc   [2] = '{3, 1};
  logic        e_pl [2];
  logic        e_rd [2];

  logic        o_pl [2];
  logic        o_rd [2];
  logic [15:0] o_ir [2];
  logic [15:0] o_pc [2];
  logic        o_nop[2];
  logic [3:0]  o_op [2];
  logic [2:0]  o_s1 [2];
  logic [2:0]  o_s2 [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ir[k] = 16'h0000; m_pc[k] = 16'h0000; m_nop[k] = 1'b1; m_rem[k] = 0;
    end
  endtask

  task automatic model_step(input logic fl, input logic bu, input logic rs,
                            input logic [15:0] rd, input logic [15:0] pi);
    logic [3:0] op;
    bit         ctrl;
    for (int k = 0; k < 2; k++) begin
      op   = m_ir[k][15:12];
      ctrl = (op == 4'h0 && !m_nop[k]) || op == 4'h4 || op == 4'hC;
      e_rd[k] = (m_rem[k] == 0);
      if (m_rem[k] != 0) begin
        m_ir[k] = 16'h0000; m_nop[k] = 1'b1; e_pl[k] = fl;
        m_rem[k] = fl ? 0 : m_rem[k] - 1;
      end else if (fl) begin
        e_pl[k] = 1'b1; m_ir[k] = 16'h0000; m_nop[k] = 1'b1;
      end else if (bu) begin
        e_pl[k] = 1'b0;
        if (ctrl) begin
          m_ir[k] = 16'h0000; m_nop[k] = 1'b1; m_rem[k] = sc[k];
        end
      end else if (rs) begin
        e_pl[k] = 1'b1; m_ir[k] = rd; m_pc[k] = pi + 16'd2; m_nop[k] = 1'b0;
      end else begin
        e_pl[k] = 1'b0; m_ir[k] = 16'h0000; m_nop[k] = 1'b1;
      end
    end
  endtask

  task automatic sample_regs();
    o_ir[0] = bus0.ir_out; o_pc[0] = bus0.pc_out; o_nop[0] = bus0.is_nop;
    o_op[0] = bus0.opcode_out; o_s1[0] = bus0.sr1_out; o_s2[0] = bus0.sr2_out;
    o_ir[1] = bus1.ir_out; o_pc[1] = bus1.pc_out; o_nop[1] = bus1.is_nop;
    o_op[1] = bus1.opcode_out; o_s1[1] = bus1.sr1_out; o_s2[1] = bus1.sr2_out;
  endtask

  // Called at posedge+1: drive, sample combinational outputs, clock, sample registers.
  task automatic tick(input logic fl, input logic bu, input logic rs,
                      input logic [15:0] rd, input logic [15:0] pi);
    bus0.flush = fl; bus0.bubble_enable = bu; bus0.imem_resp = rs;
    bus0.imem_rdata = rd; bus0.pc_in = pi;
    #3;
    o_pl[0] = bus0.pc_load; o_rd[0] = bus0.imem_read;
    o_pl[1] = bus1.pc_load; o_rd[1] = bus1.imem_read;
    model_step(fl, bu, rs, rd, pi);
    @(posedge clk); #1;
    sample_regs();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus0.flush = 1'b0; bus0.bubble_enable = 1'b0; bus0.imem_resp = 1'b0;
    bus0.imem_rdata = 16'h0; bus0.pc_in = 16'h0;
    #1 rst_n = 1'b0;
    #2;
    total++; if (bus0.ir_out !== 16'h0000) $display("FAIL reset_ir: got %h want 0000", bus0.ir_out); else passed++;
    total++; if (bus0.pc_out !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", bus0.pc_out); else passed++;
    total++; if (bus0.is_nop !== 1'b1) $display("FAIL reset_nop: got %b want 1", bus0.is_nop); else passed++;
    total++; if (bus0.imem_read !== 1'b0) $display("FAIL reset_imem_read: got %b want 0", bus0.imem_read); else passed++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    tick(1'b0, 1'b0, 1'b1, 16'h1283, 16'h3000);
    total++; if (o_pl[0] !== 1'b1) $display("FAIL fetch_pc_load: got %b want 1", o_pl[0]); else passed++;
    total++; if (o_rd[0] !== 1'b1) $display("FAIL fetch_imem_read: got %b want 1", o_rd[0]); else passed++;
    total++; if (o_ir[0] !== 16'h1283) $display("FAIL fetch_ir: got %h want 1283", o_ir[0]); else passed++;
    total++; if (o_pc[0] !== 16'h3002) $display("FAIL fetch_pc: got %h want 3002", o_pc[0]); else passed++;
    total++; if (o_nop[0] !== 1'b0) $display("FAIL fetch_nop: got %b want 0", o_nop[0]); else passed++;
    total++; if (o_op[0] !== 4'h1 || o_s1[0] !== 3'd2 || o_s2[0] !== 3'd3)
      $display("FAIL fetch_decode: got op=%h sr1=%0d sr2=%0d want op=1 sr1=2 sr2=3", o_op[0], o_s1[0], o_s2[0]); else passed++;
  endtask

  task automatic test_data_stall();
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
      total++; if (o_pl[0] !== 1'b0) $display("FAIL stall_pc_load[%0d]: got %b want 0", i, o_pl[0]); else passed++;
      total++; if (o_ir[0] !== 16'h1283 || o_pc[0] !== 16'h3002 || o_nop[0] !== 1'b0)
        $display("FAIL stall_hold[%0d]: got ir=%h pc=%h nop=%b want ir=1283 pc=3002 nop=0", i, o_ir[0], o_pc[0], o_nop[0]); else passed++;
    end
  endtask

  task automatic test_ctrl_shadow();
    tick(1'b0, 1'b0, 1'b1, 16'h0E05, 16'h3010);
    tick(1'b0, 1'b1, 1'b1, 16'h1111, 16'h3012);
    total++; if (o_pl[0] !== 1'b0 || o_nop[0] !== 1'b1 || o_ir[0] !== 16'h0000)
      $display("FAIL shadow_enter: got pl=%b nop=%b ir=%h want pl=0 nop=1 ir=0000", o_pl[0], o_nop[0], o_ir[0]); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 16'h2222, 16'h3012);
      total++; if (o_rd[0] !== 1'b0 || o_pl[0] !== 1'b0 || o_nop[0] !== 1'b1 || o_ir[0] !== 16'h0000)
        $display("FAIL shadow_cycle[%0d]: got rd=%b pl=%b nop=%b ir=%h want rd=0 pl=0 nop=1 ir=0000", i, o_rd[0], o_pl[0], o_nop[0], o_ir[0]); else passed++;
      if (i < 2) begin
        total++; if (o_rd[1] !== (i != 0)) $display("FAIL shadow1_read[%0d]: got %b want %b", i, o_rd[1], (i != 0)); else passed++;
      end
    end
    tick(1'b0, 1'b0, 1'b1, 16'h1283, 16'h3020);
    total++; if (o_rd[0] !== 1'b1 || o_pl[0] !== 1'b1 || o_ir[0] !== 16'h1283 || o_pc[0] !== 16'h3022)
      $display("FAIL shadow_exit: got rd=%b pl=%b ir=%h pc=%h want rd=1 pl=1 ir=1283 pc=3022", o_rd[0], o_pl[0], o_ir[0], o_pc[0]); else passed++;
    tick(1'b0, 1'b0, 1'b1, 16'hC1C0, 16'h3022);
    tick(1'b0, 1'b1, 1'b0, 16'h0, 16'h3024);
    tick(1'b0, 1'b0, 1'b1, 16'h3333, 16'h3024);
    tick(1'b1, 1'b0, 1'b1, 16'h3333, 16'h4000);
    total++; if (o_pl[0] !== 1'b1 || o_rd[0] !== 1'b0)
      $display("FAIL shadow_flush: got pl=%b rd=%b want pl=1 rd=0", o_pl[0], o_rd[0]); else passed++;
    tick(1'b0, 1'b0, 1'b1, 16'h5123, 16'h4000);
    total++; if (o_rd[0] !== 1'b1 || o_ir[0] !== 16'h5123 || o_pc[0] !== 16'h4002)
      $display("FAIL flush_refetch: got rd=%b ir=%h pc=%h want rd=1 ir=5123 pc=4002", o_rd[0], o_ir[0], o_pc[0]); else passed++;
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h4002);
      total++; if (o_pl[0] !== 1'b0 || o_nop[0] !== 1'b1 || o_pc[0] !== 16'h4002)
        $display("FAIL wait[%0d]: got pl=%b nop=%b pc=%h want pl=0 nop=1 pc=4002", i, o_pl[0], o_nop[0], o_pc[0]); else passed++;
    end
    tick(1'b0, 1'b0, 1'b1, 16'h1A42, 16'h4002);
    total++; if (o_pl[0] !== 1'b1 || o_ir[0] !== 16'h1A42 || o_pc[0] !== 16'h4004 || o_nop[0] !== 1'b0)
      $display("FAIL wait_resume: got pl=%b ir=%h pc=%h nop=%b want pl=1 ir=1A42 pc=4004 nop=0", o_pl[0], o_ir[0], o_pc[0], o_nop[0]); else passed++;
  endtask

  task automatic test_wrap_priority();
    tick(1'b0, 1'b0, 1'b1, 16'h5000, 16'hFFFE);
    total++; if (o_pc[0] !== 16'h0000 || o_ir[0] !== 16'h5000)
      $display("FAIL wrap: got pc=%h ir=%h want pc=0000 ir=5000", o_pc[0], o_ir[0]); else passed++;
    tick(1'b1, 1'b1, 1'b1, 16'h6789, 16'h1234);
    total++; if (o_pl[0] !== 1'b1 || o_ir[0] !== 16'h0000 || o_nop[0] !== 1'b1 || o_pc[0] !== 16'h0000)
      $display("FAIL priority: got pl=%b ir=%h nop=%b pc=%h want pl=1 ir=0000 nop=1 pc=0000", o_pl[0], o_ir[0], o_nop[0], o_pc[0]); else passed++;
  endtask

  task automatic test_reset_mid_shadow();
    tick(1'b0, 1'b0, 1'b1, 16'h4800, 16'h2000);
    tick(1'b0, 1'b1, 1'b1, 16'h0, 16'h2002);
    bus0.flush = 1'b1; bus0.imem_resp = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus0.ir_out !== 16'h0000 || bus0.is_nop !== 1'b1 || bus0.pc_out !== 16'h0000)
      $display("FAIL midreset_regs: got ir=%h nop=%b pc=%h want ir=0000 nop=1 pc=0000", bus0.ir_out, bus0.is_nop, bus0.pc_out); else passed++;
    total++; if (bus0.imem_read !== 1'b0 || bus0.pc_load !== 1'b0)
      $display("FAIL midreset_ctrl: got rd=%b pl=%b want rd=0 pl=0", bus0.imem_read, bus0.pc_load); else passed++;
    model_reset();
    bus0.flush = 1'b0; bus0.bubble_enable = 1'b0; bus0.imem_resp = 1'b0;
    rst_n = 1'b1;
    #0;
    total++; if (bus0.imem_read !== 1'b1) $display("FAIL midreset_fetch: got rd=%b want 1", bus0.imem_read); else passed++;
    model_step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic fl, bu, rs;
    logic [15:0] rd;
    logic [3:0]  ops [4];
    ops[0] = 4'h0; ops[1] = 4'h4; ops[2] = 4'hC; ops[3] = 4'h1;
    for (int n = 0; n < 400; n++) begin
      fl = ($urandom_range(0, 9) == 0);
      bu = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 3) != 0);
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rd[15:12] = ops[$urandom_range(0, 3)];
      tick(fl, bu, rs, rd, 16'($urandom));
      for (int k = 0; k < 2; k++) begin
        total++; if (o_pl[k] !== e_pl[k] || o_rd[k] !== e_rd[k])
          $display("FAIL rand_ctrl[%0d] dut%0d: got pl=%b rd=%b want pl=%b rd=%b", n, k, o_pl[k], o_rd[k], e_pl[k], e_rd[k]); else passed++;
        total++; if (o_ir[k] !== m_ir[k] || o_pc[k] !== m_pc[k] || o_nop[k] !== m_nop[k])
          $display("FAIL rand_regs[%0d] dut%0d: got ir=%h pc=%h nop=%b want ir=%h pc=%h nop=%b", n, k, o_ir[k], o_pc[k], o_nop[k], m_ir[k], m_pc[k], m_nop[k]); else passed++;
        total++; if (o_op[k] !== m_ir[k][15:12] || o_s1[k] !== m_ir[k][8:6] || o_s2[k] !== m_ir[k][2:0])
          $display("FAIL rand_decode[%0d] dut%0d: got op=%h sr1=%0d sr2=%0d for ir=%h", n, k, o_op[k], o_s1[k], o_s2[k], m_ir[k]); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_data_stall();
    test_ctrl_shadow();
    test_mem_wait();
    test_wrap_priority();
    test_reset_mid_shadow();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
